// File: rtl/wired_bus_arbiter_if.sv
// Shared-bus bundle between N wired-bus clients and the arbiter.
// Clients use the master view and the arbiter uses the slave view.
interface wired_bus_arbiter_if #(
    parameter int N = 4,
    parameter int W = 8
);
    localparam int OW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]   req;
    logic [N-1:0]   en;
    logic [N*W-1:0] d;
    logic [N-1:0]   gnt;
    logic [OW-1:0]  owner_id;
    logic [W-1:0]   bus_q;
    logic           bus_valid;
    logic           conflict;
    logic           violation;
    logic           timeout;

    modport master (
        output req, en, d,
        input  gnt, owner_id, bus_q, bus_valid, conflict, violation, timeout
    );

    modport slave (
        input  req, en, d,
        output gnt, owner_id, bus_q, bus_valid, conflict, violation, timeout
    );
endinterface

// File: rtl/wired_bus_arbiter.sv
// N-channel wired-AND/OR bus with a round-robin owner arbiter (hold limit plus one-cycle gap)
// and a registered resolved value with conflict/violation/timeout pulses.
module wired_bus_arbiter #(
    parameter int N        = 4,
    parameter int W        = 8,
    parameter int MODE     = 0,
    parameter int HOLD_MAX = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    wired_bus_arbiter_if.slave   bus
);
    localparam int OW = (N > 1) ? $clog2(N) : 1;
    localparam int HW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    localparam logic [W-1:0]  IDLE_VAL  = (MODE == 0) ? {W{1'b1}} : {W{1'b0}};
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);

    logic [1:0]    r_state;
    logic [N-1:0]  r_gnt;
    logic [OW-1:0] r_owner;
    logic [HW-1:0] r_hold;
    logic [W-1:0]  r_bus_q;
    logic          r_valid;
    logic          r_conflict;
    logic          r_violation;
    logic          r_timeout;

    logic [W-1:0]  w_masked [N];
    logic [N-1:0]  w_disagree;
    logic [W-1:0]  w_res;
    logic          w_found;
    logic [OW-1:0] w_winner;
    logic [OW-1:0] w_idx;

    // A channel that is not enabled contributes the identity value of the wired function.
    for (genvar gi = 0; gi < N; gi++) begin : g_chan
        assign w_masked[gi]   = bus.en[gi] ? bus.d[gi*W +: W] : IDLE_VAL;
        assign w_disagree[gi] = bus.en[gi] && (bus.d[gi*W +: W] != w_res);
    end

    always_comb begin
        w_res = IDLE_VAL;
        for (int i = 0; i < N; i++) begin
            if (MODE == 0) w_res = w_res & w_masked[i];
            else           w_res = w_res | w_masked[i];
        end
    end

    // Round-robin search starts one past the last owner and wraps.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_owner;
        w_idx    = r_owner;
        for (int k = 1; k <= N; k++) begin
            w_idx = OW'((32'(r_owner) + k) % N);
            if (!w_found && bus.req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_gnt       <= '0;
            r_owner     <= OW'(N - 1);
            r_hold      <= '0;
            r_bus_q     <= IDLE_VAL;
            r_valid     <= 1'b0;
            r_conflict  <= 1'b0;
            r_violation <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_bus_q     <= w_res;
            r_valid     <= (r_state == S_GRANT) && bus.en[r_owner];
            r_conflict  <= |w_disagree;
            r_violation <= |(bus.en & ~r_gnt);
            r_timeout   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_gnt   <= N'(1) << w_winner;
                        r_owner <= w_winner;
                        r_hold  <= '0;
                        r_state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    // Release wins over timeout when both happen together.
                    if (!bus.req[r_owner]) begin
                        r_gnt   <= '0;
                        r_state <= S_GAP;
                    end else if (r_hold == HOLD_LAST) begin
                        r_gnt     <= '0;
                        r_timeout <= 1'b1;
                        r_state   <= S_GAP;
                    end else begin
                        r_hold <= r_hold + 1'b1;
                    end
                end
                S_GAP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_gnt   <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.owner_id  = r_owner;
    assign bus.bus_q     = r_bus_q;
    assign bus.bus_valid = r_valid;
    assign bus.conflict  = r_conflict;
    assign bus.violation = r_violation;
    assign bus.timeout   = r_timeout;
endmodule

// File: tb/tb_wired_bus_arbiter.sv
// Directed bench: a wired-AND instance (HOLD_MAX=4) driven from a vector table,
// plus hand sequences for asynchronous reset and a wired-OR instance.
module tb_wired_bus_arbiter;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    wired_bus_arbiter_if #(.N(4), .W(8)) if0 ();
    wired_bus_arbiter_if #(.N(4), .W(8)) if1 ();

    wired_bus_arbiter #(.N(4), .W(8), .MODE(0), .HOLD_MAX(4)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0)
    );

    wired_bus_arbiter #(.N(4), .W(8), .MODE(1), .HOLD_MAX(4)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    typedef struct packed {
        logic [3:0]  req;
        logic [3:0]  en;
        logic [31:0] d;
        logic [3:0]  gnt;
        logic [1:0]  owner;
        logic [7:0]  bus_q;
        logic        valid;
        logic        conf;
        logic        viol;
        logic        tmo;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic [3:0] req, input logic [3:0] en, input logic [31:0] d,
                                input logic [3:0] gnt, input logic [1:0] owner, input logic [7:0] bq,
                                input logic valid, input logic conf, input logic viol, input logic tmo);
        vec_t v;
        v.req = req; v.en = en; v.d = d; v.gnt = gnt; v.owner = owner; v.bus_q = bq;
        v.valid = valid; v.conf = conf; v.viol = viol; v.tmo = tmo;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        // Stimulus applied at the negedge, results checked one clock later.
        vecs[0]  = mk(4'b0000, 4'b0000, 32'h0,         4'b0000, 2'd3, 8'hFF, 0, 0, 0, 0);
        vecs[1]  = mk(4'b0101, 4'b0000, 32'h0,         4'b0001, 2'd0, 8'hFF, 0, 0, 0, 0);
        vecs[2]  = mk(4'b0101, 4'b0000, 32'h0,         4'b0001, 2'd0, 8'hFF, 0, 0, 0, 0);
        vecs[3]  = mk(4'b0100, 4'b0000, 32'h0,         4'b0000, 2'd0, 8'hFF, 0, 0, 0, 0);
        vecs[4]  = mk(4'b0100, 4'b0000, 32'h0,         4'b0000, 2'd0, 8'hFF, 0, 0, 0, 0);
        vecs[5]  = mk(4'b0100, 4'b0000, 32'h0,         4'b0100, 2'd2, 8'hFF, 0, 0, 0, 0);
        vecs[6]  = mk(4'b0001, 4'b0000, 32'h0,         4'b0000, 2'd2, 8'hFF, 0, 0, 0, 0);
        vecs[7]  = mk(4'b0001, 4'b0000, 32'h0,         4'b0000, 2'd2, 8'hFF, 0, 0, 0, 0);
        vecs[8]  = mk(4'b0001, 4'b0000, 32'h0,         4'b0001, 2'd0, 8'hFF, 0, 0, 0, 0);
        vecs[9]  = mk(4'b0001, 4'b0011, 32'h0000_3CF0, 4'b0001, 2'd0, 8'h30, 1, 1, 1, 0);
        vecs[10] = mk(4'b0001, 4'b0001, 32'h0000_3CF0, 4'b0001, 2'd0, 8'hF0, 1, 0, 0, 0);
        vecs[11] = mk(4'b0001, 4'b0000, 32'h0,         4'b0001, 2'd0, 8'hFF, 0, 0, 0, 0);
        vecs[12] = mk(4'b0001, 4'b0000, 32'h0,         4'b0000, 2'd0, 8'hFF, 0, 0, 0, 1);
        vecs[13] = mk(4'b0001, 4'b0000, 32'h0,         4'b0000, 2'd0, 8'hFF, 0, 0, 0, 0);
        vecs[14] = mk(4'b0001, 4'b0000, 32'h0,         4'b0001, 2'd0, 8'hFF, 0, 0, 0, 0);
        vecs[15] = mk(4'b0001, 4'b0000, 32'h0,         4'b0001, 2'd0, 8'hFF, 0, 0, 0, 0);
        vecs[16] = mk(4'b0001, 4'b0000, 32'h0,         4'b0001, 2'd0, 8'hFF, 0, 0, 0, 0);
        vecs[17] = mk(4'b0001, 4'b0000, 32'h0,         4'b0001, 2'd0, 8'hFF, 0, 0, 0, 0);
        vecs[18] = mk(4'b0000, 4'b0000, 32'h0,         4'b0000, 2'd0, 8'hFF, 0, 0, 0, 0);
        vecs[19] = mk(4'b0000, 4'b0000, 32'h0,         4'b0000, 2'd0, 8'hFF, 0, 0, 0, 0);
        vecs[20] = mk(4'b0000, 4'b0100, 32'h0055_0000, 4'b0000, 2'd0, 8'h55, 0, 0, 1, 0);
        vecs[21] = mk(4'b0010, 4'b0000, 32'h0,         4'b0010, 2'd1, 8'hFF, 0, 0, 0, 0);
        vecs[22] = mk(4'b0100, 4'b0000, 32'h0,         4'b0000, 2'd1, 8'hFF, 0, 0, 0, 0);
        vecs[23] = mk(4'b0100, 4'b0000, 32'h0,         4'b0000, 2'd1, 8'hFF, 0, 0, 0, 0);
        vecs[24] = mk(4'b0100, 4'b0000, 32'h0,         4'b0100, 2'd2, 8'hFF, 0, 0, 0, 0);

        if0.req = '0; if0.en = '0; if0.d = '0;
        if1.req = '0; if1.en = '0; if1.d = '0;

        repeat (3) @(negedge clk);
        chk("rst_gnt",       32'(if0.gnt),       32'h0);
        chk("rst_owner",     32'(if0.owner_id),  32'h3);
        chk("rst_bus_q",     32'(if0.bus_q),     32'hFF);
        chk("rst_flags",     32'({if0.bus_valid, if0.conflict, if0.violation, if0.timeout}), 32'h0);
        chk("rst_bus_q_or",  32'(if1.bus_q),     32'h00);
        $display("reset: gnt=%b bus_q=%h bus_q_or=%h", if0.gnt, if0.bus_q, if1.bus_q);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            if0.req = vecs[i].req;
            if0.en  = vecs[i].en;
            if0.d   = vecs[i].d;
            step();
            $display("vec %0d: req=%b en=%b -> gnt=%b owner=%0d bus_q=%h v=%b c=%b x=%b t=%b",
                     i, vecs[i].req, vecs[i].en, if0.gnt, if0.owner_id, if0.bus_q,
                     if0.bus_valid, if0.conflict, if0.violation, if0.timeout);
            chk($sformatf("v%0d_gnt", i),   32'(if0.gnt),       32'(vecs[i].gnt));
            chk($sformatf("v%0d_owner", i), 32'(if0.owner_id),  32'(vecs[i].owner));
            chk($sformatf("v%0d_bus_q", i), 32'(if0.bus_q),     32'(vecs[i].bus_q));
            chk($sformatf("v%0d_valid", i), 32'(if0.bus_valid), 32'(vecs[i].valid));
            chk($sformatf("v%0d_conf", i),  32'(if0.conflict),  32'(vecs[i].conf));
            chk($sformatf("v%0d_viol", i),  32'(if0.violation), 32'(vecs[i].viol));
            chk($sformatf("v%0d_tmo", i),   32'(if0.timeout),   32'(vecs[i].tmo));
        end

        // Asynchronous reset while ch2 owns the bus: outputs clear before any clock edge.
        if0.req = 4'b0100;
        if0.en  = 4'b0100;
        if0.d   = 32'h0012_0000;
        step();
        rst_n = 1'b0;
        #1;
        $display("async reset: gnt=%b owner=%0d bus_q=%h", if0.gnt, if0.owner_id, if0.bus_q);
        chk("arst_gnt",   32'(if0.gnt),       32'h0);
        chk("arst_owner", 32'(if0.owner_id),  32'h3);
        chk("arst_bus_q", 32'(if0.bus_q),     32'hFF);
        chk("arst_valid", 32'(if0.bus_valid), 32'h0);
        @(negedge clk);
        if0.req = 4'b1111;
        if0.en  = 4'b0000;
        if0.d   = '0;
        rst_n   = 1'b1;
        step();
        $display("after reset req=1111: gnt=%b owner=%0d", if0.gnt, if0.owner_id);
        chk("rr_restart_gnt",   32'(if0.gnt),      32'h1);
        chk("rr_restart_owner", 32'(if0.owner_id), 32'h0);

        // Wired-OR instance.
        if1.en = 4'b0000;
        if1.d  = 32'hFFFF_FFFF;
        step();
        $display("or: en=%b -> bus_q=%h c=%b", if1.en, if1.bus_q, if1.conflict);
        chk("or_idle_bus_q", 32'(if1.bus_q),    32'h00);
        chk("or_idle_conf",  32'(if1.conflict), 32'h0);
        if1.en = 4'b0110;
        if1.d  = 32'h0018_8100;
        step();
        $display("or: en=%b -> bus_q=%h c=%b x=%b", if1.en, if1.bus_q, if1.conflict, if1.violation);
        chk("or_bus_q", 32'(if1.bus_q),     32'h99);
        chk("or_conf",  32'(if1.conflict),  32'h1);
        chk("or_viol",  32'(if1.violation), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
